hidden_cpu_feeder: RTL and testbench
====================================

Name: hidden_cpu_feeder

Overview:
- Host-side driver for the 8-bit-pin tiny CPU core: the other end of its `in[7:0]`/`out[7:0]` pin interface.
- Stores a small program and generates the CPU's pin-level clock on `in[0]` and reset on `in[1]`.
- Each CPU cycle it presents the instruction (opcode plus two register addresses) on `in[7:2]`, then samples `out[7:0]` to choose the next instruction.
- Sits in the test harness / FPGA wrapper, clocked by the fast system clock.

Parameters:
- DEPTH, 16, program memory entries (power of 2, max 256).
- HALF_PERIOD, 2, system clocks per CPU clock phase (low and high), min 1.
- RST_CYCLES, 2, CPU clock periods with CPU reset held high at start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- prog_we  in  1  program write strobe
- prog_addr  in  log2(DEPTH)  program write address
- prog_data  in  6  instruction: [1:0] opcode, [3:2] reg0 addr, [5:4] reg1 addr
- prog_len  in  log2(DEPTH)+1  number of valid instructions
- step_limit  in  8  max CPU cycles to run; 0 means unlimited
- start  in  1  one-cycle run request
- cpu_in  out  8  to CPU pins: [0] cpu clock, [1] cpu reset, [3:2] opcode, [5:4] reg0, [7:6] reg1
- cpu_out  in  8  from CPU pins (taken as PC)
- busy  out  1  run in progress
- done  out  1  run finished, held until next start or rst
- err  out  1  run halted because PC was >= prog_len
- last_out  out  8  cpu_out captured at the most recent step
- steps  out  8  CPU cycles executed in current/last run

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; cpu_in=0; busy=0; done=0; err=0; last_out=0; steps=0. Program memory contents are not cleared.
- Program memory is written on `prog_we` only in IDLE/DONE; writes in any other state are ignored. It is read combinationally.
- FSM states: IDLE, RSTLO, RSTHI, LOAD, CLKLO, CLKHI, CHECK, DONE.
- `start` in IDLE or DONE: clear done, err and steps; set busy; go to RSTLO.
- `start` while busy is ignored.
- RSTLO/RSTHI:
  - cpu_in[1]=1 and cpu_in[7:2]=0.
  - cpu_in[0]=0 for HALF_PERIOD clocks, then 1 for HALF_PERIOD clocks.
  - Repeat RST_CYCLES times, then go to LOAD with cpu_in[1]=0.
- LOAD (1 clock):
  - PC = cpu_out.
  - If PC >= prog_len: go to DONE with err=1.
  - Else drive cpu_in[7:2] = mem[PC[log2(DEPTH)-1:0]] with cpu_in[0]=0; go to CLKLO.
- CLKLO: hold for HALF_PERIOD clocks, instruction stable; go to CLKHI.
- CLKHI:
  - cpu_in[0]=1, which is the CPU rising edge; hold HALF_PERIOD clocks; instruction unchanged throughout.
  - On exit: cpu_in[0]=0, last_out=cpu_out, steps = steps+1 (saturating at 255).
- CHECK (1 clock): if step_limit != 0 and steps == step_limit, go to DONE; else go to LOAD.
- DONE: busy=0, done=1; cpu_in holds 0 except instruction bits, which are cleared to 0.
- Per CPU cycle latency: 2*HALF_PERIOD + 2 system clocks.
- rst mid-run aborts immediately to IDLE with outputs at their reset values.
- prog_len=0: first LOAD sets err.
- prog_len > DEPTH is clamped to DEPTH.

Optional Feature:
- Macro HIDDENCPU_FEEDER_TRACE_EN.
- When defined, adds outputs `trace_valid` (1) and `trace_data` (16).
  - `trace_valid` pulses for one clock on each CHECK entry.
  - `trace_data` = {steps[7:0], last_out[7:0]}.
- When undefined, the ports are absent and there is no trace logic.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - Opcode constants: ADD=2'b00, SUB=2'b01, BRANCH=2'b10, TOGGLE=2'b11.
  - Pin-bit index constants: CPU_CLK_BIT=0, CPU_RST_BIT=1, OP_LSB=2.
- One natural sub-module: `hidden_cpu_clkgen`, the HALF_PERIOD phase counter producing phase-done strobes.

Test Plan:
- Load 4 instructions, prog_len=4, step_limit=3, with CPU model returning PC=steps. Start → cpu_in[1]=1 for 2 CPU periods; then instructions mem[0], mem[1], mem[2] stable across each cpu_in[0] rising edge; done=1, steps=3, err=0.
- HALF_PERIOD=1 → each CPU clock period is 2 system clocks; CHECK-to-CHECK spacing is 4 clocks.
- CPU model returns cpu_out=8'h05 with prog_len=4 → err=1, done=1 after LOAD; steps=0; no cpu_in[0] rising edge after reset phase.
- Assert rst during CLKHI → next clock: cpu_in=0, busy=0, steps=0; a following start replays the reset sequence.
- prog_we during busy → memory unchanged (readback via next run drives old value); start during busy → no effect on steps.
- step_limit=0 with CPU model looping PC 0..3 → steps saturates at 255; busy stays 1; trace_valid (if enabled) pulses once per cycle with trace_data[7:0] matching cpu_out.

Source files
------------

// File: rtl/hidden_cpu_feeder_pkg.sv
// Shared types and constants for the tiny-CPU pin feeder.
package hidden_cpu_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_RSTLO, S_RSTHI, S_LOAD, S_CLKLO, S_CLKHI, S_CHECK, S_DONE
  } state_e;

  // CPU opcodes carried in prog_data[1:0]
  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  // Bit positions on the CPU input pins
  localparam int CPU_CLK_BIT = 0;
  localparam int CPU_RST_BIT = 1;
  localparam int OP_LSB      = 2;

  localparam logic [7:0] PIN_CLK = 8'h01 << CPU_CLK_BIT;
  localparam logic [7:0] PIN_RST = 8'h01 << CPU_RST_BIT;

  function automatic logic [7:0] sat_inc8(logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hidden_cpu_feeder_if.sv
// Host/CPU-pin bundle for hidden_cpu_feeder.
// HIDDENCPU_FEEDER_TRACE_EN adds the trace_valid/trace_data signals.
interface hidden_cpu_feeder_if #(parameter int DEPTH = 16);
  localparam int AW = $clog2(DEPTH);

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [5:0]    prog_data;
  logic [AW:0]   prog_len;
  logic [7:0]    step_limit;
  logic          start;
  logic [7:0]    cpu_in;
  logic [7:0]    cpu_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    last_out;
  logic [7:0]    steps;
`ifdef HIDDENCPU_FEEDER_TRACE_EN
  logic          trace_valid;
  logic [15:0]   trace_data;

  modport master (output prog_we, prog_addr, prog_data, prog_len, step_limit, start, cpu_out,
                  input  cpu_in, busy, done, err, last_out, steps, trace_valid, trace_data);
  modport slave  (input  prog_we, prog_addr, prog_data, prog_len, step_limit, start, cpu_out,
                  output cpu_in, busy, done, err, last_out, steps, trace_valid, trace_data);
`else
  modport master (output prog_we, prog_addr, prog_data, prog_len, step_limit, start, cpu_out,
                  input  cpu_in, busy, done, err, last_out, steps);
  modport slave  (input  prog_we, prog_addr, prog_data, prog_len, step_limit, start, cpu_out,
                  output cpu_in, busy, done, err, last_out, steps);
`endif
endinterface

// File: rtl/hidden_cpu_clkgen.sv
// Half-period phase counter: phase_done fires on the last clock of each
// HALF_PERIOD-long phase while en is high; the count restarts at 0 after
// every strobe or whenever en drops.
module hidden_cpu_clkgen #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_done
);
  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_done = en && (cnt_q == LAST);

  // Advance within a phase, restart at phase boundaries or when idle
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en || phase_done) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/hidden_cpu_feeder.sv
// Host-side driver for the 8-pin tiny CPU: holds a small program, generates
// the CPU clock/reset pins, presents one instruction per CPU cycle and uses
// the CPU's output pins as the PC for the next fetch.
// Optional macro HIDDENCPU_FEEDER_TRACE_EN adds a per-cycle trace strobe.
module hidden_cpu_feeder
  import hidden_cpu_feeder_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int HALF_PERIOD = 2,
  parameter int RST_CYCLES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  hidden_cpu_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_e      state_q, state_d;
  logic [7:0]  cpu_in_q, cpu_in_d;
  logic [7:0]  last_out_q, last_out_d;
  logic [7:0]  steps_q, steps_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [5:0]  mem_q [DEPTH];
  logic [AW:0] len_eff;
  logic        pc_bad;
  logic        phase_en, phase_done;

  hidden_cpu_clkgen #(.HALF_PERIOD(HALF_PERIOD)) u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .en         (phase_en),
    .phase_done (phase_done)
  );

  // Only the timed pin phases run the half-period counter
  assign phase_en = state_q inside {S_RSTLO, S_RSTHI, S_CLKLO, S_CLKHI};
  // A length beyond the store size is treated as the full store
  assign len_eff  = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;
  assign pc_bad   = {1'b0, bus.cpu_out} >= 9'(len_eff);

  // Program store: writable only while no run is in flight
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state_q == S_IDLE || state_q == S_DONE))
      mem_q[bus.prog_addr] <= bus.prog_data;
  end

  // Run sequencer: reset pulses, then fetch/clock/check per CPU cycle
  always_comb begin
    state_d    = state_q;
    cpu_in_d   = cpu_in_q;
    last_out_d = last_out_q;
    steps_d    = steps_q;
    rcnt_d     = rcnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          done_d   = 1'b0;
          err_d    = 1'b0;
          steps_d  = '0;
          busy_d   = 1'b1;
          rcnt_d   = '0;
          cpu_in_d = PIN_RST;
          state_d  = S_RSTLO;
        end
      end
      S_RSTLO: begin
        if (phase_done) begin
          cpu_in_d = PIN_RST | PIN_CLK;
          state_d  = S_RSTHI;
        end
      end
      S_RSTHI: begin
        if (phase_done) begin
          if (rcnt_q == 8'(RST_CYCLES - 1)) begin
            cpu_in_d = '0;
            state_d  = S_LOAD;
          end else begin
            rcnt_d   = rcnt_q + 8'd1;
            cpu_in_d = PIN_RST;
            state_d  = S_RSTLO;
          end
        end
      end
      S_LOAD: begin
        cpu_in_d = '0;
        if (pc_bad) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cpu_in_d[7:OP_LSB] = mem_q[bus.cpu_out[AW-1:0]];
          state_d            = S_CLKLO;
        end
      end
      S_CLKLO: begin
        if (phase_done) begin
          cpu_in_d[CPU_CLK_BIT] = 1'b1;
          state_d               = S_CLKHI;
        end
      end
      S_CLKHI: begin
        if (phase_done) begin
          cpu_in_d[CPU_CLK_BIT] = 1'b0;
          last_out_d            = bus.cpu_out;
          steps_d               = sat_inc8(steps_q);
          state_d               = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bus.step_limit != 8'd0 && steps_q == bus.step_limit) begin
          cpu_in_d = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cpu_in_q   <= '0;
      last_out_q <= '0;
      steps_q    <= '0;
      rcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_in_q   <= cpu_in_d;
      last_out_q <= last_out_d;
      steps_q    <= steps_d;
      rcnt_q     <= rcnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.cpu_in   = cpu_in_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.last_out = last_out_q;
  assign bus.steps    = steps_q;

`ifdef HIDDENCPU_FEEDER_TRACE_EN
  logic trace_valid_q, trace_valid_d;

  // Strobe for the single CHECK clock of each CPU cycle
  always_comb begin
    trace_valid_d = (state_d == S_CHECK);
  end

  // Trace strobe register
  always_ff @(posedge clk) begin
    if (rst) trace_valid_q <= 1'b0;
    else     trace_valid_q <= trace_valid_d;
  end

  assign bus.trace_valid = trace_valid_q;
  assign bus.trace_data  = {steps_q, last_out_q};
`endif
endmodule

// File: tb/tb_hidden_cpu_feeder.sv
// Scoreboard bench for hidden_cpu_feeder with a behavioural CPU model.
module tb_hidden_cpu_feeder;
  import hidden_cpu_feeder_pkg::*;

  localparam int DEPTH = 16;
  localparam int HP    = 2;
  localparam int RSTC  = 2;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed { logic [7:0] steps; logic err; logic [7:0] last; } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hidden_cpu_feeder_if #(.DEPTH(DEPTH)) bus();
  hidden_cpu_feeder #(.DEPTH(DEPTH), .HALF_PERIOD(HP), .RST_CYCLES(RSTC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] mem_m [DEPTH];
  logic [7:0] rnd_pc [64];
  int         mode = 0;
  logic [7:0] m_last = 8'd0;
  logic [5:0] exp_q [$];
  res_t       res_q [$];

  task automatic chk(string name, int act, int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // CPU behaviour: PC after reset, and PC after the k-th executed instruction
  function automatic int init_pc(int m);
    return (m == 1) ? 5 : 0;
  endfunction

  function automatic int next_pc(int m, int pc, int k);
    case (m)
      0:       return (pc + 1) % 256;
      1:       return 5;
      2:       return (pc + 1) % 4;
      default: return int'(rnd_pc[k % 64]);
    endcase
  endfunction

  function automatic logic [5:0] rand_instr();
    logic [1:0] op;
    case ($urandom_range(0, 3))
      0:       op = OP_ADD;
      1:       op = OP_SUB;
      2:       op = OP_BRANCH;
      default: op = OP_TOGGLE;
    endcase
    return {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), op};
  endfunction

  // CPU pin model: acts on each rising edge of its clock pin
  logic [7:0] cpu_pc = 8'd0;
  int         cpu_k  = 0;
  bit         cm_prev = 1'b0;
  assign bus.cpu_out = cpu_pc;

  initial forever begin
    @(negedge clk);
    if (bus.cpu_in[0] && !cm_prev) begin
      if (bus.cpu_in[1]) begin
        cpu_pc = 8'(init_pc(mode));
        cpu_k  = 0;
      end else begin
        cpu_pc = 8'(next_pc(mode, int'(cpu_pc), cpu_k));
        cpu_k++;
      end
    end
    cm_prev = bus.cpu_in[0];
  end

  // Reference run: expected instruction per CPU edge, plus final result
  task automatic predict(int m, int len, int limit);
    int pc, st, leff, k;
    res_t r;
    bit fin;
    leff = (len > DEPTH) ? DEPTH : len;
    pc = init_pc(m); st = 0; k = 0; fin = 1'b0;
    r = '0; r.last = m_last;
    while (!fin && k < 300) begin
      if (pc >= leff) begin
        r.err = 1'b1;
        fin   = 1'b1;
      end else begin
        exp_q.push_back(mem_m[pc]);
        pc = next_pc(m, pc, k);
        k++;
        r.last = 8'(pc);
        st = (st < 255) ? st + 1 : 255;
        if (limit != 0 && st == limit) fin = 1'b1;
      end
    end
    r.steps = 8'(st);
    if (fin) begin
      res_q.push_back(r);
      m_last = r.last;
    end
  endtask

  // Monitor: checks each CPU edge and each run completion against the queues
  int         cyc = 0, last_edge = 0, rst_edges = 0, run_edges = 0;
  bit         mp_c0 = 1'b0, mp_busy = 1'b0, mp_done = 1'b0;
  logic [5:0] hold = '0, e_ins;
  res_t       r_exp;
`ifdef HIDDENCPU_FEEDER_TRACE_EN
  int         last_tr = 0;
  bit         tr_seen = 1'b0;
`endif

  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      res_q.delete();
      mp_c0 = 1'b0; mp_busy = 1'b0; mp_done = 1'b0;
    end else begin
      if (bus.busy && !mp_busy) begin
        rst_edges = 0;
        run_edges = 0;
`ifdef HIDDENCPU_FEEDER_TRACE_EN
        tr_seen = 1'b0;
`endif
      end
      if (bus.cpu_in[0] && !mp_c0) begin
        if (bus.cpu_in[1]) begin
          if (rst_edges > 0) chk("rst_period", cyc - last_edge, 2 * HP);
          rst_edges++;
        end else begin
          if (run_edges > 0) chk("cpu_period", cyc - last_edge, 2 * HP + 2);
          chk("edge_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e_ins = exp_q.pop_front();
            chk("instr", int'(bus.cpu_in[7:2]), int'(e_ins));
          end
          hold = bus.cpu_in[7:2];
          run_edges++;
        end
        last_edge = cyc;
      end else if (bus.cpu_in[0] && !bus.cpu_in[1]) begin
        chk("instr_hold", int'(bus.cpu_in[7:2]), int'(hold));
      end
      if (bus.done && !mp_done) begin
        chk("result_expected", int'(res_q.size() > 0), 1);
        if (res_q.size() > 0) begin
          r_exp = res_q.pop_front();
          chk("steps", int'(bus.steps), int'(r_exp.steps));
          chk("err", int'(bus.err), int'(r_exp.err));
          chk("last_out", int'(bus.last_out), int'(r_exp.last));
          chk("done_busy", int'(bus.busy), 0);
          chk("done_cpu_in", int'(bus.cpu_in), 0);
          chk("rst_pulses", rst_edges, RSTC);
          chk("instr_left", exp_q.size(), 0);
        end
      end
`ifdef HIDDENCPU_FEEDER_TRACE_EN
      if (bus.trace_valid) begin
        chk("trace_steps", int'(bus.trace_data[15:8]), (run_edges > 255) ? 255 : run_edges);
        chk("trace_out", int'(bus.trace_data[7:0]), int'(cpu_pc));
        if (tr_seen) chk("trace_period", cyc - last_tr, 2 * HP + 2);
        tr_seen = 1'b1;
        last_tr = cyc;
      end
`endif
      mp_c0   = bus.cpu_in[0];
      mp_busy = bus.busy;
      mp_done = bus.done;
    end
    cyc++;
  end

  // Stimulus helpers (all called at a negedge)
  task automatic write_mem(int a, logic [5:0] d, bit upd);
    bus.prog_we   = 1'b1;
    bus.prog_addr = AW'(a);
    bus.prog_data = d;
    @(negedge clk);
    bus.prog_we   = 1'b0;
    if (upd) mem_m[a] = d;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(int bound);
    for (int i = 0; i < bound && !bus.done; i++) @(negedge clk);
    chk("run_done", int'(bus.done), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic setup(int m, int len, int limit);
    mode           = m;
    bus.prog_len   = (AW+1)'(len);
    bus.step_limit = 8'(limit);
    predict(m, len, limit);
  endtask

  task automatic run(int m, int len, int limit);
    setup(m, len, limit);
    pulse_start();
    wait_done(100 + RSTC * 2 * HP + 300 * (2 * HP + 2));
  endtask

  task automatic abort_run();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cpu_in", int'(bus.cpu_in), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_steps", int'(bus.steps), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_last_out", int'(bus.last_out), 0);
    @(negedge clk);
    rst    = 1'b0;
    m_last = 8'd0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.prog_len = '0; bus.step_limit = '0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_in", int'(bus.cpu_in), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_last_out", int'(bus.last_out), 0);
    chk("rst_steps", int'(bus.steps), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) write_mem(i, rand_instr(), 1'b1);

    // Basic: PC follows step count, three steps
    run(0, 4, 3);
    // CPU reports PC out of range right after reset
    run(1, 4, 3);
    // Empty program
    run(0, 0, 5);
    // Length beyond store size: runs off the end of the clamped store
    run(0, DEPTH + 5, 0);

    // Reset in the middle of a clock-high phase, then a clean replay
    setup(0, 8, 6);
    pulse_start();
    for (int i = 0; i < 200 && !(bus.cpu_in[0] && !bus.cpu_in[1]); i++) @(negedge clk);
    chk("reach_clkhi", int'(bus.cpu_in[0] & ~bus.cpu_in[1]), 1);
    abort_run();
    run(0, 8, 6);

    // Program writes and start requests while busy are ignored
    setup(0, 4, 2);
    pulse_start();
    @(negedge clk);
    write_mem(0, mem_m[0] ^ 6'h3F, 1'b0);
    repeat (10) @(negedge clk);
    pulse_start();
    wait_done(400);
    run(0, 4, 1);

    // Randomized programs, PCs, lengths and limits
    for (int it = 0; it < 10; it++) begin
      for (int j = 0; j < 64; j++) rnd_pc[j] = 8'($urandom_range(0, DEPTH + 3));
      repeat (2) write_mem($urandom_range(0, DEPTH - 1), rand_instr(), 1'b1);
      run(3, $urandom_range(0, DEPTH + 2), $urandom_range(1, 12));
    end

    // Unlimited run over a looping PC: steps saturate, run keeps going
    setup(2, 4, 0);
    pulse_start();
    for (int i = 0; i < 300 * (2 * HP + 2) && bus.steps != 8'd255; i++) @(negedge clk);
    chk("sat_reached", int'(bus.steps), 255);
    repeat (20) @(negedge clk);
    chk("sat_hold", int'(bus.steps), 255);
    chk("sat_busy", int'(bus.busy), 1);
    chk("sat_done", int'(bus.done), 0);
    abort_run();

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
